// File: rtl/cwait_merge_n_sync.sv
// N-channel wait-merge (join). Each channel feeds its own small FIFO.
// When every enabled FIFO holds a word and the output register can take
// a beat, one word is popped from each enabled FIFO. The words are
// concatenated into a registered beat, with channel 0 in the LSBs.

// Per-channel FIFO. Full and empty are derived from read and write
// pointers that carry one extra wrap bit.
module cwait_merge_n_sync_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;

    // Storage write. The contents need no reset because the pointers
    // decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= din;
    end

    // Pointer update. Pointers wrap naturally modulo 2*DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    assign dout  = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
endmodule

module cwait_merge_n_sync #(
    parameter int N_CH  = 2,
    parameter int DW    = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_CH-1:0]    i_drive,
    input  logic [N_CH*DW-1:0] i_data,
    output logic [N_CH-1:0]    o_free,
    input  logic [N_CH-1:0]    i_chanMask,
    output logic               o_driveNext,
    output logic [N_CH*DW-1:0] o_data,
    output logic [N_CH-1:0]    o_laneMask,
    input  logic               i_freeNext,
    output logic [CNT_W-1:0]   o_mergeCount
);
    logic [N_CH-1:0]         full;
    logic [N_CH-1:0]         empty;
    logic [N_CH-1:0]         push;
    logic [N_CH-1:0]         pop;
    logic [N_CH-1:0][DW-1:0] head;
    logic [N_CH*DW-1:0]      merged;
    logic                    slot_free;
    logic                    all_ready;
    logic                    join_fire;

    // o_free depends only on registered FIFO state. A full FIFO refuses a
    // push even when it is popped on the same edge, so there is no path
    // from i_freeNext to o_free.
    assign o_free = ~full;
    assign push   = i_drive & ~full;
    assign pop    = join_fire ? i_chanMask : '0;

    for (genvar k = 0; k < N_CH; k++) begin : g_lane
        cwait_merge_n_sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[k]),
            .din   (i_data[k*DW +: DW]),
            .pop   (pop[k]),
            .dout  (head[k]),
            .full  (full[k]),
            .empty (empty[k])
        );
    end

    // A disabled channel never blocks the join. An all-zero mask never joins.
    assign slot_free = !o_driveNext || i_freeNext;
    assign all_ready = &(~i_chanMask | ~empty);
    assign join_fire = (|i_chanMask) && all_ready && slot_free;

    // Assemble the next beat. Disabled lanes read as zero.
    always_comb begin
        merged = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (i_chanMask[k]) merged[k*DW +: DW] = head[k];
        end
    end

    // Output beat register. Data and mask hold while a beat is stalled or
    // after it drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_driveNext <= 1'b0;
            o_data      <= '0;
            o_laneMask  <= '0;
        end else if (join_fire) begin
            o_driveNext <= 1'b1;
            o_data      <= merged;
            o_laneMask  <= i_chanMask;
        end else if (i_freeNext) begin
            o_driveNext <= 1'b0;
        end
    end

    // Count completed downstream handshakes. The counter wraps naturally.
    always_ff @(posedge clk) begin
        if (rst)                            o_mergeCount <= '0;
        else if (o_driveNext && i_freeNext) o_mergeCount <= o_mergeCount + CNT_W'(1);
    end
endmodule

// File: tb/tb_cwait_merge_n_sync.sv
// Directed bench for cwait_merge_n_sync with N_CH=2, DW=32, DEPTH=2,
// CNT_W=4. Inputs change 1ns after a rising edge. Outputs are checked at
// the same point, after the edge has settled.
module tb_cwait_merge_n_sync;
    localparam int N_CH = 2, DW = 32, DEPTH = 2, CNT_W = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic [N_CH-1:0]    i_drive;
    logic [N_CH*DW-1:0] i_data;
    logic [N_CH-1:0]    o_free;
    logic [N_CH-1:0]    i_chanMask;
    logic               o_driveNext;
    logic [N_CH*DW-1:0] o_data;
    logic [N_CH-1:0]    o_laneMask;
    logic               i_freeNext;
    logic [CNT_W-1:0]   o_mergeCount;

    int checks = 0;
    int errs   = 0;

    cwait_merge_n_sync #(.N_CH(N_CH), .DW(DW), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_drive      (i_drive),
        .i_data       (i_data),
        .o_free       (o_free),
        .i_chanMask   (i_chanMask),
        .o_driveNext  (o_driveNext),
        .o_data       (o_data),
        .o_laneMask   (o_laneMask),
        .i_freeNext   (i_freeNext),
        .o_mergeCount (o_mergeCount)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic beat(input string tag, input logic [63:0] d, input logic [1:0] m);
        chk({tag, " vld"},  64'(o_driveNext), 64'd1);
        chk({tag, " data"}, 64'(o_data), d);
        chk({tag, " mask"}, 64'(o_laneMask), 64'(m));
    endtask

    initial begin
        rst = 1'b1; i_drive = '0; i_data = '0; i_chanMask = 2'b11; i_freeNext = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("rst vld",  64'(o_driveNext), 64'd0);
        chk("rst data", 64'(o_data), 64'd0);
        chk("rst mask", 64'(o_laneMask), 64'd0);
        chk("rst cnt",  64'(o_mergeCount), 64'd0);
        chk("rst free", 64'(o_free), 64'd3);

        // Basic join: two cycles from push to valid output.
        i_drive = 2'b11; i_data = {32'h22222222, 32'h11111111};
        tick(); i_drive = '0;
        chk("basic lat", 64'(o_driveNext), 64'd0);
        tick();
        beat("basic", 64'h22222222_11111111, 2'b11);
        chk("basic cnt0", 64'(o_mergeCount), 64'd0);
        tick();
        chk("basic cnt", 64'(o_mergeCount), 64'd1);
        chk("basic drain", 64'(o_driveNext), 64'd0);

        // Skew: ch0 runs ahead and fills its FIFO while ch1 is idle.
        i_drive = 2'b01; i_data = {32'h0, 32'hA0}; tick();
        i_data = {32'h0, 32'hA1}; tick();
        chk("skew full", 64'(o_free), 64'd2);
        i_data = {32'h0, 32'hA2}; tick();
        chk("skew hold", 64'(o_free), 64'd2);
        chk("skew novld", 64'(o_driveNext), 64'd0);
        i_drive = 2'b11; i_data = {32'hB0, 32'hA2}; tick();
        chk("skew b0 in", 64'(o_driveNext), 64'd0);
        i_data = {32'hB1, 32'hA2}; tick();
        beat("skew b0", {32'hB0, 32'hA0}, 2'b11);
        chk("skew free", 64'(o_free), 64'd3);
        i_drive = 2'b01; tick();
        beat("skew b1", {32'hB1, 32'hA1}, 2'b11);
        i_drive = 2'b00; tick();
        chk("skew idle", 64'(o_driveNext), 64'd0);
        chk("skew cnt", 64'(o_mergeCount), 64'd3);
        i_drive = 2'b10; i_data = {32'hB2, 32'h0}; tick();
        i_drive = 2'b00; tick();
        beat("skew a2", {32'hB2, 32'hA2}, 2'b11);
        tick();
        chk("skew cnt2", 64'(o_mergeCount), 64'd4);

        // Output stall: the pending beat and the counter hold for 5 cycles.
        i_drive = 2'b11; i_data = {32'hD0, 32'hC0}; tick();
        i_data = {32'hD1, 32'hC1}; tick();
        i_drive = 2'b00; i_freeNext = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            beat("stall", {32'hD0, 32'hC0}, 2'b11);
            chk("stall cnt", 64'(o_mergeCount), 64'd4);
        end
        i_freeNext = 1'b1; tick();
        chk("release cnt", 64'(o_mergeCount), 64'd5);
        beat("release next", {32'hD1, 32'hC1}, 2'b11);
        tick();
        chk("release cnt2", 64'(o_mergeCount), 64'd6);

        // Mask 01: ch1 gets a word but is neither popped nor blocking.
        i_chanMask = 2'b01; i_drive = 2'b11; i_data = {32'h99, 32'h5}; tick();
        i_drive = 2'b00; tick();
        beat("mask01", {32'h0, 32'h5}, 2'b01);
        tick();
        chk("mask01 cnt", 64'(o_mergeCount), 64'd7);
        i_chanMask = 2'b00; i_drive = 2'b01; i_data = {32'h0, 32'h6}; tick();
        i_drive = 2'b00;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("mask00 idle", 64'(o_driveNext), 64'd0);
        end
        i_chanMask = 2'b11; tick();
        beat("mask11 kept", {32'h99, 32'h6}, 2'b11);
        tick();
        chk("mask cnt", 64'(o_mergeCount), 64'd8);

        // Reset mid-stream with both FIFOs full and a beat pending.
        i_drive = 2'b11; i_data = {32'hF0, 32'hE0}; tick();
        i_data = {32'hF1, 32'hE1}; tick();
        i_freeNext = 1'b0; i_data = {32'hF2, 32'hE2}; tick();
        chk("pre-rst free", 64'(o_free), 64'd0);
        chk("pre-rst vld", 64'(o_driveNext), 64'd1);
        rst = 1'b1; i_data = {32'hF3, 32'hE3}; tick();
        rst = 1'b0; i_drive = 2'b00; i_freeNext = 1'b1;
        chk("mrst vld",  64'(o_driveNext), 64'd0);
        chk("mrst data", 64'(o_data), 64'd0);
        chk("mrst cnt",  64'(o_mergeCount), 64'd0);
        chk("mrst free", 64'(o_free), 64'd3);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mrst stale", 64'(o_driveNext), 64'd0);
        end

        // Counter wrap: 17 back-to-back beats.
        i_drive = 2'b11; i_data = {32'h1, 32'h2};
        tick(); tick();
        for (int h = 1; h <= 17; h++) begin
            tick();
            chk("wrap cnt", 64'(o_mergeCount), 64'(h % 16));
            if (h == 17) i_drive = 2'b00;
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/cwait_merge_n_sync.md
Name: cwait_merge_n_sync

Overview:
- Clocked, parametrised N-channel wait-merge (join) for the MMU/PMP request path.
- Each channel has its own DEPTH-entry FIFO.
- When every enabled channel holds a word, one word is popped from each enabled FIFO. The words are concatenated (channel 0 in the LSBs) into a registered output beat.
- Generalises the fixed 2x32b merge: configurable channel count, width and buffering, a per-channel enable mask, and a merge counter.

Parameters:
- N_CH, 2, number of input channels (2..8)
- DW, 32, data width per channel
- DEPTH, 2, per-channel FIFO entries (power of 2, >=2)
- CNT_W, 16, width of merge counter

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- i_drive  in  N_CH  per-channel valid
- i_data  in  N_CH*DW  per-channel data; channel k at bits [k*DW +: DW]
- o_free  out  N_CH  per-channel ready (FIFO k not full)
- i_chanMask  in  N_CH  1 = channel takes part in merge
- o_driveNext  out  1  output beat valid
- o_data  out  N_CH*DW  merged beat
- o_laneMask  out  N_CH  mask value used for the current beat
- i_freeNext  in  1  downstream ready
- o_mergeCount  out  CNT_W  count of completed output handshakes

Behaviour:
- Reset (rst=1 at edge): all FIFOs empty; o_driveNext=0, o_data=0, o_laneMask=0, o_mergeCount=0; o_free=all ones in the cycle after reset.
- Channel push: when i_drive[k] & o_free[k] at an edge, i_data lane k is written to FIFO k.
- o_free[k] = !full[k], taken from registered FIFO state only. A full FIFO refuses a push even if it is popped in the same cycle. No combinational path from i_freeNext to o_free.
- Output slot is free when !o_driveNext | i_freeNext.
- join = (i_chanMask != 0) & for every k with i_chanMask[k]=1, FIFO k non-empty & output slot free.
- On join at an edge:
  - pop the head of each enabled FIFO;
  - o_data lane k = head[k] if enabled, else 0;
  - o_laneMask <= i_chanMask;
  - o_driveNext <= 1.
- Disabled channels are neither popped nor blocking. They still accept pushes until full.
- If no join occurs and i_freeNext & o_driveNext: o_driveNext <= 0. o_data and o_laneMask hold their last values.
- o_driveNext, o_data and o_laneMask stay stable while o_driveNext & !i_freeNext.
- o_mergeCount increments by 1 on each edge with o_driveNext & i_freeNext; wraps from 2^CNT_W-1 to 0.
- Latency: data pushed at edge t gives a join at edge t+1 at the earliest, so o_driveNext is high in the cycle after edge t+1 (2 cycles from input to output).
- Throughput: one beat per cycle when downstream holds i_freeNext=1 and all enabled FIFOs stay fed.
- A channel that runs ahead buffers up to DEPTH words, then o_free[k]=0.
- i_chanMask=0: no join ever fires; the pending output beat can still drain.
- i_chanMask is sampled only in the join cycle. Changing it between joins is legal and affects only later beats.
- Simultaneous push and pop on a non-full FIFO: both happen; occupancy is unchanged.
- rst asserted mid-operation: FIFO contents, pending beat and counter are discarded on that edge. i_drive in a reset cycle is ignored.
- FIFO pointers wrap modulo DEPTH. Full/empty are kept with an extra pointer bit or an occupancy counter.

Test Plan:
- Basic join, N_CH=2, DW=32, mask=2'b11, i_freeNext=1: ch0 drives 0x11111111 at cycle 0, ch1 drives 0x22222222 at cycle 0 -> o_driveNext=1 at cycle 2, o_data=0x22222222_11111111, o_laneMask=2'b11, o_mergeCount=1 one cycle later.
- Skew/backpressure: ch0 pushes 0xA0, 0xA1, 0xA2 back-to-back while ch1 is idle -> o_free[0]=0 after 2 pushes (DEPTH=2), third word held by the source. Then ch1 pushes 0xB0, 0xB1 -> beats {0xB0,0xA0} then {0xB1,0xA1}; after a free entry appears, 0xA2 is accepted.
- Output stall: i_freeNext=0 for 5 cycles with a beat pending -> o_driveNext, o_data and o_laneMask constant, o_mergeCount unchanged. Release -> count +1, next beat issued the following cycle.
- Mask: mask=2'b01 with only ch0 driving 0x5 -> beat o_data lane1=0, lane0=0x5, o_laneMask=2'b01; FIFO 1 contents untouched. Mask=2'b00 -> o_driveNext stays 0 for 10 cycles.
- Counter wrap: CNT_W=4, 17 back-to-back beats -> o_mergeCount reads 15 then 0 then 1.
- Reset mid-stream: assert rst with both FIFOs full and a beat pending -> next cycle o_driveNext=0, o_data=0, o_mergeCount=0, o_free=all ones; no stale word emerges afterwards.
